// File: rtl/gcd_arbiter.sv
// gcd_arbiter: round-robin scheduler sharing one GCD FSMD unit among N_REQ
// requesters. Operand pairs containing a zero bypass the GCD unit, and every
// run is guarded by a watchdog that aborts with resp_err after TIMEOUT cycles.
//
//   state | meaning
//   IDLE  | pick next requester round-robin from ptr, latch operands
//   ISSUE | pulse gcd_go, clear watchdog
//   WAIT  | wait for gcd_done or watchdog expiry
//   RESP  | one-cycle ack to the winner, advance ptr
module gcd_arbiter #(
    parameter int N_REQ   = 4,
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 1023
) (
    input  logic                   CLK,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] a_i,
    input  logic [N_REQ*WIDTH-1:0] b_i,
    output logic [N_REQ-1:0]       ack,
    output logic [WIDTH-1:0]       resp_data,
    output logic                   resp_err,
    output logic                   busy,
    output logic                   gcd_go,
    output logic [WIDTH-1:0]       gcd_x,
    output logic [WIDTH-1:0]       gcd_y,
    input  logic                   gcd_done,
    input  logic [WIDTH-1:0]       gcd_result
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [IW-1:0]    ptr;
    logic [IW-1:0]    sel_id;
    logic [WIDTH-1:0] x_r, y_r, res_r;
    logic             err_r;
    logic [CW-1:0]    cnt;

    logic [IW-1:0]    win;
    logic             found;
    logic [WIDTH-1:0] a_sel, b_sel;
    logic             bypass;
    logic [CW-1:0]    cnt_inc;
    logic             timeout_hit;
    logic [IW-1:0]    ptr_next;

    // Round-robin search: first set req bit at or above ptr, wrapping around.
    always_comb begin
        found = 1'b0;
        win   = ptr;
        for (int i = 0; i < N_REQ; i++) begin
            int j;
            j = int'(ptr) + i;
            if (j >= N_REQ) j = j - N_REQ;
            if (!found && req[j]) begin
                found = 1'b1;
                win   = IW'(j);
            end
        end
    end

    // Winner operands, zero detection, watchdog compare and pointer advance.
    always_comb begin
        a_sel       = a_i[int'(win)*WIDTH +: WIDTH];
        b_sel       = b_i[int'(win)*WIDTH +: WIDTH];
        bypass      = (a_sel == '0) || (b_sel == '0);
        cnt_inc     = cnt + 1'b1;
        timeout_hit = (cnt_inc == TO_VAL);
        ptr_next    = (sel_id == IW'(N_REQ - 1)) ? '0 : sel_id + 1'b1;
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; gcd_done outside WAIT has no effect.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (found) state_d = bypass ? RESP : ISSUE;
            ISSUE: state_d = WAIT;
            WAIT:  if (gcd_done || timeout_hit) state_d = RESP;
            RESP:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath registers: operand latch, watchdog, result/error capture, ptr.
    always_ff @(posedge CLK) begin
        if (reset) begin
            ptr    <= '0;
            sel_id <= '0;
            x_r    <= '0;
            y_r    <= '0;
            res_r  <= '0;
            err_r  <= 1'b0;
            cnt    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (found) begin
                        sel_id <= win;
                        x_r    <= a_sel;
                        y_r    <= b_sel;
                        // nonzero operand, or 0 when both are zero
                        if (bypass) res_r <= a_sel | b_sel;
                    end
                end
                ISSUE: cnt <= '0;
                WAIT: begin
                    cnt <= cnt_inc;
                    // completion beats a simultaneous watchdog expiry
                    if (gcd_done) begin
                        res_r <= gcd_result;
                    end else if (timeout_hit) begin
                        err_r <= 1'b1;
                        res_r <= '0;
                    end
                end
                RESP: begin
                    ptr   <= ptr_next;
                    err_r <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Outputs decoded from registered state only.
    always_comb begin
        ack = '0;
        if (state_q == RESP) ack[sel_id] = 1'b1;
        resp_data = (state_q == RESP) ? res_r : '0;
        resp_err  = (state_q == RESP) && err_r;
        busy      = (state_q != IDLE);
        gcd_go    = (state_q == ISSUE);
        gcd_x     = x_r;
        gcd_y     = y_r;
    end

endmodule

// File: tb/tb_gcd_arbiter.sv
// tb_gcd_arbiter: directed scenarios for gcd_arbiter with a behavioural GCD
// unit. Expected responses go into a scoreboard queue; a monitor pops and
// compares on every ack. Each GCD start is checked against its own queue.
module tb_gcd_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic           CLK;
    logic           reset;
    logic [N-1:0]   req;
    logic [N*W-1:0] a_i, b_i;
    logic [N-1:0]   ack;
    logic [W-1:0]   resp_data;
    logic           resp_err;
    logic           busy;
    logic           gcd_go;
    logic [W-1:0]   gcd_x, gcd_y;
    logic           gcd_done;
    logic [W-1:0]   gcd_result;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int         id;
        logic [W-1:0] data;
        logic       err;
        int         at;
    } resp_t;

    typedef struct {
        logic [W-1:0] x;
        logic [W-1:0] y;
        int           lat;
    } go_t;

    resp_t sb[$];
    go_t   goq[$];

    gcd_arbiter #(.N_REQ(N), .WIDTH(W), .TIMEOUT(15)) dut (
        .CLK(CLK), .reset(reset), .req(req), .a_i(a_i), .b_i(b_i),
        .ack(ack), .resp_data(resp_data), .resp_err(resp_err), .busy(busy),
        .gcd_go(gcd_go), .gcd_x(gcd_x), .gcd_y(gcd_y),
        .gcd_done(gcd_done), .gcd_result(gcd_result)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Cycle counter, read at negedges.
    always @(posedge CLK) cyc <= cyc + 1;

    function automatic logic [W-1:0] gcd_f(input logic [W-1:0] x0, input logic [W-1:0] y0);
        logic [W-1:0] x, y, t;
        x = x0;
        y = y0;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Response monitor: every ack pops one scoreboard entry.
    always @(negedge CLK) begin
        if (ack != '0) begin
            resp_t e;
            logic [N-1:0] exp_ack;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_ack: ack=%b data=%0d err=%0d cyc=%0d, required no ack",
                         ack, resp_data, resp_err, cyc);
            end else begin
                e = sb.pop_front();
                exp_ack = N'(1 << e.id);
                if (ack !== exp_ack || resp_data !== e.data || resp_err !== e.err ||
                    (e.at >= 0 && cyc != e.at)) begin
                    errors++;
                    $display("FAIL resp: got ack=%b data=%0d err=%0d cyc=%0d, required ack=%b data=%0d err=%0d cyc=%0d",
                             ack, resp_data, resp_err, cyc, exp_ack, e.data, e.err, e.at);
                end
            end
        end
    end

    // Behavioural GCD unit plus start checker; lat 0 means it never finishes.
    initial begin
        int  pend;
        logic [W-1:0] xl, yl;
        pend = -1;
        xl = '0;
        yl = '0;
        gcd_done = 1'b0;
        gcd_result = '0;
        forever begin
            @(negedge CLK);
            gcd_done = 1'b0;
            if (reset) begin
                pend = -1;
            end else begin
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) begin
                        gcd_done   = 1'b1;
                        gcd_result = gcd_f(xl, yl);
                        pend       = -1;
                    end
                end
                if (gcd_go) begin
                    go_t g;
                    checks++;
                    xl = gcd_x;
                    yl = gcd_y;
                    if (goq.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_go: x=%0d y=%0d, required no gcd_go", gcd_x, gcd_y);
                        pend = 3;
                    end else begin
                        g = goq.pop_front();
                        if (gcd_x !== g.x || gcd_y !== g.y) begin
                            errors++;
                            $display("FAIL go_operands: got x=%0d y=%0d, required x=%0d y=%0d",
                                     gcd_x, gcd_y, g.x, g.y);
                        end
                        pend = (g.lat > 0) ? g.lat : -1;
                    end
                end
            end
        end
    end

    task automatic raise(input int id, input logic [W-1:0] a, input logic [W-1:0] b);
        a_i[id*W +: W] = a;
        b_i[id*W +: W] = b;
        req[id] = 1'b1;
    endtask

    // off = ack cycle relative to the IDLE cycle in which req is raised; -1 = any.
    task automatic expect_resp(input int id, input logic [W-1:0] d, input logic e, input int off);
        resp_t r;
        r.id = id;
        r.data = d;
        r.err = e;
        r.at = (off < 0) ? -1 : cyc + off;
        sb.push_back(r);
    endtask

    task automatic expect_go(input logic [W-1:0] x, input logic [W-1:0] y, input int lat);
        go_t g;
        g.x = x;
        g.y = y;
        g.lat = lat;
        goq.push_back(g);
    endtask

    task automatic wait_ack(input int id, input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge CLK);
            if (ack[id]) ok = 1'b1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout: no ack[%0d] within %0d cycles, required one", id, budget);
        end
    endtask

    task automatic chk_zero(input string name);
        logic [N+3*W+3:0] v;
        v = {ack, resp_data, resp_err, busy, gcd_go, gcd_x, gcd_y};
        checks++;
        if (v !== '0) begin
            errors++;
            $display("FAIL %s: outputs ack=%b data=%0d err=%b busy=%b go=%b x=%0d y=%0d, required all 0",
                     name, ack, resp_data, resp_err, busy, gcd_go, gcd_x, gcd_y);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int order[5];
        order = '{0, 1, 2, 3, 0};
        reset = 1'b1;
        req   = '0;
        a_i   = '0;
        b_i   = '0;
        repeat (3) @(negedge CLK);
        chk_zero("reset_outputs");
        reset = 1'b0;

        // All four requesting; requester 0 re-requests with new operands.
        @(negedge CLK);
        raise(0, 12, 8);
        raise(1, 21, 14);
        raise(2, 9, 6);
        raise(3, 100, 75);
        expect_go(12, 8, 3);
        expect_go(21, 14, 3);
        expect_go(9, 6, 3);
        expect_go(100, 75, 3);
        expect_go(35, 15, 3);
        expect_resp(0, 4, 1'b0, 5);
        expect_resp(1, 7, 1'b0, -1);
        expect_resp(2, 3, 1'b0, -1);
        expect_resp(3, 25, 1'b0, -1);
        expect_resp(0, 5, 1'b0, -1);
        for (int k = 0; k < 5; k++) begin
            wait_ack(order[k], 60);
            if (k == 0) raise(0, 35, 15);
            else        req[order[k]] = 1'b0;
        end

        // Single normal run.
        @(negedge CLK);
        raise(0, 48, 18);
        expect_go(48, 18, 3);
        expect_resp(0, 6, 1'b0, 5);
        wait_ack(0, 60);
        req[0] = 1'b0;

        // Bypass paths.
        @(negedge CLK);
        raise(2, 0, 35);
        expect_resp(2, 35, 1'b0, 1);
        wait_ack(2, 20);
        req[2] = 1'b0;
        @(negedge CLK);
        raise(2, 0, 0);
        expect_resp(2, 0, 1'b0, 1);
        wait_ack(2, 20);
        req[2] = 1'b0;
        @(negedge CLK);
        raise(2, 20, 0);
        expect_resp(2, 20, 1'b0, 1);
        wait_ack(2, 20);
        req[2] = 1'b0;

        // Reset during WAIT (ptr is 3 beforehand).
        @(negedge CLK);
        raise(0, 50, 20);
        expect_go(50, 20, 0);
        repeat (5) @(negedge CLK);
        reset = 1'b1;
        req   = '0;
        @(negedge CLK);
        chk_zero("reset_in_wait");
        reset = 1'b0;
        @(negedge CLK);
        raise(1, 16, 12);
        raise(3, 18, 27);
        expect_go(16, 12, 3);
        expect_go(18, 27, 3);
        expect_resp(1, 4, 1'b0, 5);
        expect_resp(3, 9, 1'b0, -1);
        wait_ack(1, 60);
        req[1] = 1'b0;
        wait_ack(3, 60);
        req[3] = 1'b0;

        // Watchdog timeout, then the next requester is served.
        @(negedge CLK);
        raise(1, 60, 45);
        raise(2, 27, 18);
        expect_go(60, 45, 0);
        expect_go(27, 18, 3);
        expect_resp(1, 0, 1'b1, 17);
        expect_resp(2, 9, 1'b0, -1);
        wait_ack(1, 60);
        req[1] = 1'b0;
        wait_ack(2, 60);
        req[2] = 1'b0;

        // gcd_done in the same cycle as the watchdog expiry.
        @(negedge CLK);
        raise(3, 60, 45);
        expect_go(60, 45, 15);
        expect_resp(3, 15, 1'b0, 17);
        wait_ack(3, 60);
        req[3] = 1'b0;

        // Move ptr to 1, then requester 3 drops req during WAIT.
        @(negedge CLK);
        raise(0, 7, 0);
        expect_resp(0, 7, 1'b0, 1);
        wait_ack(0, 20);
        req[0] = 1'b0;
        @(negedge CLK);
        raise(3, 81, 27);
        expect_go(81, 27, 6);
        expect_resp(3, 27, 1'b0, 8);
        repeat (3) @(negedge CLK);
        req[3] = 1'b0;
        wait_ack(3, 60);

        // ptr must now be 0: requester 0 beats requester 2.
        @(negedge CLK);
        raise(2, 45, 30);
        raise(0, 14, 21);
        expect_go(14, 21, 3);
        expect_go(45, 30, 3);
        expect_resp(0, 7, 1'b0, 5);
        expect_resp(2, 15, 1'b0, -1);
        wait_ack(0, 60);
        req[0] = 1'b0;
        wait_ack(2, 60);
        req[2] = 1'b0;

        repeat (5) @(negedge CLK);
        checks++;
        if (sb.size() != 0 || goq.size() != 0) begin
            errors++;
            $display("FAIL leftover: %0d responses and %0d starts still expected, required 0 and 0",
                     sb.size(), goq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
